pe_edge_feeder: RTL

Drives one edge lane of the PE systolic array: reads a row/column of signed 8-bit operands from an operand RAM and streams them into the first PE's `inX_vld`/`inX_data` pair, together with the lane's `pe_en`. Each lane instance applies a fixed start skew so that data wavefronts arrive diagonally across the array. After streaming, it holds `pe_en` for a drain window so downstream PEs can flush their products. The array top instantiates one per row (`in0` side) and one per column (`in1` side).

---
 rtl/pe_pkg.sv | 21 ++
 rtl/pe_feed_ctr.sv | 28 ++
 rtl/pe_edge_feeder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the PE array edge feeders: operand/product widths,
// the feeder FSM state type and a counter-width helper.
package pe_pkg;

   localparam int unsigned OPND_W = 8;
   localparam int unsigned PROD_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SKEW,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } feed_state_e;

   // Number of bits needed to hold the value v (at least one).
   function automatic int unsigned bits_for(input int unsigned v);
      return (v < 2) ? 1 : $clog2(v + 1);
   endfunction

endpackage

// File: rtl/pe_feed_ctr.sv
// Loadable down-counter with a zero flag; shared by the feeder for its
// skew, stream and drain phases. Saturates at zero.
module pe_feed_ctr #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   // Load takes priority over decrement; decrement stops at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/pe_edge_feeder.sv
// Edge-lane feeder for the PE systolic array: waits SKEW cycles after an
// accepted start, reads len operands from the operand RAM, streams them to
// the first PE and holds pe_en through a drain window.
// Optional feature: define PE_FEED_ZERO_PAD_EN to keep out_vld high with
// zero data during the drain window.
module pe_edge_feeder
   import pe_pkg::*;
#(
   parameter int unsigned SKEW   = 0,
   parameter int unsigned DRAIN  = 0,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [OPND_W-1:0] ram_rd_data,
   output logic              out_vld,
   output logic [OPND_W-1:0] out_data,
   output logic              pe_en
);

   localparam int unsigned CNT_A = (LEN_W > bits_for(SKEW)) ? LEN_W : bits_for(SKEW);
   localparam int unsigned CNT_W = (CNT_A > bits_for(DRAIN)) ? CNT_A : bits_for(DRAIN);

   feed_state_e       state_q;
   feed_state_e       state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  len_q;
   logic              rd_vld_q;
   logic              accept;
   logic              ctr_load;
   logic              ctr_dec;
   logic [CNT_W-1:0]  ctr_val;
   logic [CNT_W-1:0]  ctr_count;
   logic              ctr_zero;

   assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   // Each phase loads the counter with (cycles - 1) and leaves on zero.
   pe_feed_ctr #(
      .W (CNT_W)
   ) u_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ctr_load),
      .load_val (ctr_val),
      .dec      (ctr_dec),
      .count    (ctr_count),
      .zero     (ctr_zero)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and phase-counter control.
   always_comb begin
      state_d  = state_q;
      ctr_load = 1'b0;
      ctr_dec  = 1'b0;
      ctr_val  = '0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
            if (start) begin
               if (len == '0) begin
                  state_d = ST_DONE;
               end else if (SKEW > 0) begin
                  state_d  = ST_SKEW;
                  ctr_load = 1'b1;
                  ctr_val  = CNT_W'(SKEW) - CNT_W'(1);
               end else begin
                  state_d  = ST_STREAM;
                  ctr_load = 1'b1;
                  ctr_val  = CNT_W'(len) - CNT_W'(1);
               end
            end
         end
         ST_SKEW: begin
            if (ctr_zero) begin
               state_d  = ST_STREAM;
               ctr_load = 1'b1;
               ctr_val  = CNT_W'(len_q) - CNT_W'(1);
            end else begin
               ctr_dec = 1'b1;
            end
         end
         // DRAIN always lasts DRAIN+1 cycles: the first one carries the
         // final operand returned by the RAM.
         ST_STREAM: begin
            if (ctr_zero) begin
               state_d  = ST_DRAIN;
               ctr_load = 1'b1;
               ctr_val  = CNT_W'(DRAIN);
            end else begin
               ctr_dec = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (ctr_zero) begin
               state_d = ST_DONE;
            end else begin
               ctr_dec = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Transfer parameters, read address walk and read-data valid tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         len_q    <= '0;
         rd_vld_q <= 1'b0;
      end else begin
         rd_vld_q <= (state_q == ST_STREAM);
         if (accept) begin
            addr_q <= base_addr;
            len_q  <= len;
         end else if (state_q == ST_STREAM) begin
            addr_q <= addr_q + ADDR_W'(1);
         end
      end
   end

   // Outputs decoded from the state and data-valid registers.
   always_comb begin
      busy        = (state_q == ST_SKEW) || (state_q == ST_STREAM) || (state_q == ST_DRAIN);
      done        = (state_q == ST_DONE);
      ram_rd_en   = (state_q == ST_STREAM);
      ram_rd_addr = addr_q;
      pe_en       = rd_vld_q || (state_q == ST_DRAIN);
`ifdef PE_FEED_ZERO_PAD_EN
      out_vld     = rd_vld_q || (state_q == ST_DRAIN);
`else
      out_vld     = rd_vld_q;
`endif
      out_data    = rd_vld_q ? ram_rd_data : '0;
   end

endmodule
